// File: rtl/dtree_eval_sequencer.sv
// Serial feature collector and result sequencer for the decision-tree classifier.
// Optional idle timeout inside a frame is enabled by defining DTREE_SEQ_TIMEOUT_EN.
module dtree_eval_sequencer #(
  parameter int unsigned NUM_FEATURES   = 45,
  parameter int unsigned FEAT_W         = 8,
  parameter int unsigned CLASS_W        = 5,
  parameter int unsigned EVAL_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [FEAT_W-1:0]                in_data,
  input  logic                             in_last,
  output logic [NUM_FEATURES*FEAT_W-1:0]   feat_bus,
  output logic                             tree_en,
  input  logic [CLASS_W-1:0]               class_in,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [CLASS_W-1:0]               res_class,
  output logic [1:0]                       err_code,
  output logic                             busy
);

  localparam int unsigned IDX_W = $clog2(NUM_FEATURES);
  localparam int unsigned CNT_W = $clog2(EVAL_CYCLES + 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_FEATURES - 1);
  localparam logic [CNT_W-1:0] EVAL_LOAD = CNT_W'(EVAL_CYCLES);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StLoad  = 3'd1;
  localparam logic [2:0] StDrain = 3'd2;
  localparam logic [2:0] StEval  = 3'd3;
  localparam logic [2:0] StHold  = 3'd4;

  if (NUM_FEATURES < 2 || EVAL_CYCLES < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("dtree_eval_sequencer: invalid parameter set");
  end

  logic [2:0]                     state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [CLASS_W-1:0]             res_class_q, res_class_d;
  logic                           res_valid_q, res_valid_d;
  logic [1:0]                     err_q, err_d;
  logic [NUM_FEATURES*FEAT_W-1:0] feat_q;
  logic                           feat_we;
  logic [IDX_W-1:0]               feat_wr_idx;
  logic                           beat;

`ifdef DTREE_SEQ_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_q, to_d;
`endif

  assign in_ready  = (state_q == StIdle) || (state_q == StLoad) || (state_q == StDrain);
  assign beat      = in_valid && in_ready;
  assign tree_en   = (state_q == StEval);
  assign busy      = (state_q != StIdle);
  assign feat_bus  = feat_q;
  assign res_valid = res_valid_q;
  assign res_class = res_class_q;
  assign err_code  = err_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    res_class_d = res_class_q;
    res_valid_d = res_valid_q;
    err_d       = 2'b00;
    feat_we     = 1'b0;
    feat_wr_idx = idx_q;
    case (state_q)
      StIdle: begin
        if (beat) begin
          feat_we     = 1'b1;
          feat_wr_idx = '0;
          idx_d       = IDX_W'(1);
          if (in_last) begin
            err_d = 2'b01;
          end else begin
            state_d = StLoad;
          end
        end
      end
      StLoad: begin
        if (beat) begin
          feat_we = 1'b1;
          if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (in_last) begin
              state_d = StEval;
              cnt_d   = EVAL_LOAD;
            end else begin
              err_d   = 2'b10;
              state_d = StDrain;
            end
          end else if (in_last) begin
            err_d   = 2'b01;
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      StDrain: begin
        if (beat && in_last) begin
          state_d = StIdle;
        end
      end
      StEval: begin
        // Capture on the edge where the counter would reach zero.
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d       = '0;
          res_class_d = class_in;
          res_valid_d = 1'b1;
          state_d     = StHold;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      StHold: begin
        if (res_valid_q && res_ready) begin
          res_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

`ifdef DTREE_SEQ_TIMEOUT_EN
    to_d = '0;
    if (state_q == StLoad || state_q == StDrain) begin
      if (beat) begin
        to_d = '0;
      end else if (to_q == TO_LAST) begin
        to_d    = '0;
        err_d   = 2'b11;
        idx_d   = '0;
        state_d = StIdle;
      end else begin
        to_d = to_q + TO_W'(1);
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cnt_q       <= '0;
      res_class_q <= '0;
      res_valid_q <= 1'b0;
      err_q       <= 2'b00;
      feat_q      <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      res_class_q <= res_class_d;
      res_valid_q <= res_valid_d;
      err_q       <= err_d;
      if (feat_we) begin
        feat_q[int'(feat_wr_idx)*FEAT_W +: FEAT_W] <= in_data;
      end
    end
  end

`ifdef DTREE_SEQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_q <= '0;
    end else begin
      to_q <= to_d;
    end
  end
`endif

endmodule

// File: tb/tb_dtree_eval_sequencer.sv
// Directed self-checking bench for dtree_eval_sequencer.
// Timeout checks follow DTREE_SEQ_TIMEOUT_EN (bench uses TIMEOUT_CYCLES=8).
module tb_dtree_eval_sequencer;

  localparam int unsigned NF = 45;
  localparam int unsigned FW = 8;
  localparam int unsigned CW = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [FW-1:0]      in_data;
  logic               in_last;
  logic [NF*FW-1:0]   feat_bus;
  logic               tree_en;
  logic [CW-1:0]      class_in;
  logic               res_valid;
  logic               res_ready;
  logic [CW-1:0]      res_class;
  logic [1:0]         err_code;
  logic               busy;

  int checks   = 0;
  int failures = 0;

  dtree_eval_sequencer #(
    .NUM_FEATURES  (NF),
    .FEAT_W        (FW),
    .CLASS_W       (CW),
    .EVAL_CYCLES   (4),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .feat_bus (feat_bus),
    .tree_en  (tree_en),
    .class_in (class_in),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_class(res_class),
    .err_code (err_code),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [FW-1:0] slot(input int i);
    return feat_bus[i*FW +: FW];
  endfunction

  // Streams n back-to-back beats with data base+i; last_pos < 0 means no in_last.
  task automatic send(input int n, input int last_pos, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      chk("beat_ready", 64'(in_ready), 64'(1));
      in_data  = base + 8'(i);
      in_last  = (i == last_pos);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits the evaluation window, checks the result, then completes the handshake.
  task automatic expect_result(input logic [CW-1:0] cls, input string tag);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk({tag, "_eval_no_valid"}, 64'(res_valid), 64'(0));
    end
    tick();
    chk({tag, "_valid"}, 64'(res_valid), 64'(1));
    chk({tag, "_class"}, 64'(res_class), 64'(cls));
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk({tag, "_done_busy"}, 64'(busy), 64'(0));
    chk({tag, "_done_valid"}, 64'(res_valid), 64'(0));
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    class_in  = '0;
    res_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_res_class", 64'(res_class), 64'(0));
    chk("rst_err", 64'(err_code), 64'(0));
    chk("rst_tree_en", 64'(tree_en), 64'(0));
    chk("rst_feat_zero", 64'(feat_bus == '0), 64'(1));
    rst_n = 1'b1;
    tick();

    // Nominal frame, data = index+1, class 13
    class_in = 5'd13;
    send(45, 44, 8'h01);
    chk("nom_tree_en", 64'(tree_en), 64'(1));
    chk("nom_in_ready", 64'(in_ready), 64'(0));
    chk("nom_busy", 64'(busy), 64'(1));
    chk("nom_slot0", 64'(slot(0)), 64'h01);
    chk("nom_slot44", 64'(slot(44)), 64'h2D);
    chk("nom_slot20", 64'(slot(20)), 64'h15);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("nom_tree_en_hold", 64'(tree_en), 64'(1));
      chk("nom_early_valid", 64'(res_valid), 64'(0));
    end
    tick();
    chk("nom_valid_lat4", 64'(res_valid), 64'(1));
    chk("nom_class", 64'(res_class), 64'(13));
    chk("nom_tree_en_off", 64'(tree_en), 64'(0));

    // Back-pressure: class_in moves but the captured result must not
    class_in = 5'd7;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_valid", 64'(res_valid), 64'(1));
      chk("bp_class", 64'(res_class), 64'(13));
      chk("bp_in_ready", 64'(in_ready), 64'(0));
    end
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    chk("bp_release_valid", 64'(res_valid), 64'(0));
    chk("bp_release_busy", 64'(busy), 64'(0));
    chk("bp_release_ready", 64'(in_ready), 64'(1));
    class_in = 5'd2;
    send(45, 44, 8'h11);
    chk("f2_slot44", 64'(slot(44)), 64'h3D);
    expect_result(5'd2, "f2");

    // Short frame, in_last on beat 9
    send(10, 9, 8'h40);
    chk("short_err", 64'(err_code), 64'(1));
    chk("short_busy", 64'(busy), 64'(0));
    tick();
    chk("short_err_clear", 64'(err_code), 64'(0));
    chk("short_no_valid", 64'(res_valid), 64'(0));

    // Single-beat frame is short too
    send(1, 0, 8'h55);
    chk("single_err", 64'(err_code), 64'(1));
    chk("single_busy", 64'(busy), 64'(0));
    tick();
    chk("single_err_clear", 64'(err_code), 64'(0));

    // Long frame: 50 beats, in_last on beat 49
    send(45, -1, 8'h80);
    chk("long_err", 64'(err_code), 64'(2));
    chk("long_drain_busy", 64'(busy), 64'(1));
    chk("long_drain_ready", 64'(in_ready), 64'(1));
    send(5, 4, 8'hAD);
    chk("long_err_clear", 64'(err_code), 64'(0));
    chk("long_idle", 64'(busy), 64'(0));
    chk("long_no_valid", 64'(res_valid), 64'(0));
    chk("long_slot0_kept", 64'(slot(0)), 64'h80);
    chk("long_slot44_kept", 64'(slot(44)), 64'hAC);
    class_in = 5'd13;
    send(45, 44, 8'h01);
    chk("after_long_slot0", 64'(slot(0)), 64'h01);
    expect_result(5'd13, "after_long");

    // Reset during EVAL
    class_in = 5'd21;
    send(45, 44, 8'h01);
    tick();
    tick();
    chk("mid_in_eval", 64'(tree_en), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_tree_en", 64'(tree_en), 64'(0));
    chk("mid_busy", 64'(busy), 64'(0));
    chk("mid_valid", 64'(res_valid), 64'(0));
    chk("mid_feat_zero", 64'(feat_bus == '0), 64'(1));
    chk("mid_in_ready", 64'(in_ready), 64'(1));
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("mid_no_result", 64'(res_valid), 64'(0));
    end
    class_in = 5'd9;
    send(45, 44, 8'h01);
    expect_result(5'd9, "after_rst");

    // Stall after 20 beats
    send(20, -1, 8'h01);
    chk("stall_busy", 64'(busy), 64'(1));
`ifdef DTREE_SEQ_TIMEOUT_EN
    for (int k = 0; k < 7; k++) begin
      tick();
      chk("to_wait_err", 64'(err_code), 64'(0));
      chk("to_wait_busy", 64'(busy), 64'(1));
    end
    tick();
    chk("to_err", 64'(err_code), 64'(3));
    chk("to_idle", 64'(busy), 64'(0));
    tick();
    chk("to_err_clear", 64'(err_code), 64'(0));
`else
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("stall_err", 64'(err_code), 64'(0));
      chk("stall_still_busy", 64'(busy), 64'(1));
    end
    chk("stall_in_ready", 64'(in_ready), 64'(1));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
